// File: rtl/rr_grant_arbiter_pkg.sv
// Package shared by the round-robin grant arbiter slice.
//   arb_state_e : arbitration FSM states (free arbitration / holding an owner)
//   rr_pick_t   : result of a round-robin search (found flag + index)
//   rr_first    : first set request at or after a pointer, wrapping at n
// Requester count is limited to RR_MAX_N by the width of the search helper.
package rr_grant_arbiter_pkg;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan n requesters starting at ptr; ptr < n is assumed, so a single
  // subtraction is enough to wrap the candidate index.
  function automatic rr_pick_t rr_first(input logic [RR_MAX_N-1:0] req,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int unsigned         n);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned off = 0; off < RR_MAX_N; off++) begin
      k = 32'(ptr) + off;
      if (k >= n) k = k - n;
      if (off < n && !pick.found && req[k[RR_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = k[RR_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_out_buf2.sv
// Two-entry output FIFO with a valid/ready read side.
//   CLK, Reset   : clock, asynchronous active-low reset
//   i_Wr/i_WrData: write one entry (caller guarantees space)
//   o_Valid/o_Data/i_Ready : head of FIFO, popped when o_Valid && i_Ready
//   o_Occ        : current occupancy 0..2
// Simultaneous write and pop are allowed at any occupancy the caller permits.
module arb_out_buf2 #(
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          i_Wr,
  input  logic [DW-1:0] i_WrData,
  output logic          o_Valid,
  output logic [DW-1:0] o_Data,
  input  logic          i_Ready,
  output logic [1:0]    o_Occ
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          pop;

  assign pop = o_Valid && i_Ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (i_Wr) begin
        mem[wr_ptr] <= i_WrData;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, i_Wr} - {1'b0, pop};
    end
  end

  assign o_Valid = (count != 2'd0);
  assign o_Data  = mem[rd_ptr];
  assign o_Occ   = count;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one downstream stream between N bypass queues.
//   CLK, Reset : clock, asynchronous active-low reset
//   i_Req      : per-queue request (queue o_Grant)
//   i_Mask     : per-queue disable, treated as no request
//   i_Data     : per-queue data, slice k = [k*WIDTH +: WIDTH]
//   o_Grant    : one-hot/zero pop grant, combinational from i_Req
//   o_Valid/o_Data/o_Src/i_Ready : output buffer head stream
// A grant is only issued when a slot in the 2-entry output buffer is reserved
// for it; the granted queue's data is captured one cycle after the grant.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MAX_HOLD = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [N-1:0]         i_Req,
  input  logic [N-1:0]         i_Mask,
  input  logic [N*WIDTH-1:0]   i_Data,
  output logic [N-1:0]         o_Grant,
  output logic                 o_Valid,
  output logic [WIDTH-1:0]     o_Data,
  output logic [$clog2(N)-1:0] o_Src,
  input  logic                 i_Ready
);

  localparam int unsigned SRC_W  = $clog2(N);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e          state, state_n;
  logic [SRC_W-1:0]    ptr, ptr_n;
  logic [SRC_W-1:0]    owner, owner_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [SRC_W-1:0]    arb_ptr;
  logic [SRC_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic                do_arb;
  logic                cap_vld;
  logic [SRC_W-1:0]    cap_sel;
  logic [WIDTH-1:0]    cap_data;
  logic [N-1:0]        req_eff;
  logic [1:0]          occ;
  logic [2:0]          inflight;
  logic                pop;
  logic                allowed;
  rr_pick_t            pick;
  logic [SRC_W+WIDTH-1:0] buf_wdata;
  logic [SRC_W+WIDTH-1:0] buf_rdata;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign req_eff = i_Req & ~i_Mask;
  assign pop     = o_Valid && i_Ready;

  // Entries buffered plus the one being captured, less the one leaving now.
  assign inflight = {1'b0, occ} + {2'b00, cap_vld} - {2'b00, pop};
  assign allowed  = Reset && (inflight < 3'd2);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    hold_n  = hold_cnt;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    do_arb  = 1'b0;
    arb_ptr = ptr;
    pick    = '0;
    if (allowed) begin
      unique case (state)
        ST_ARB: do_arb = 1'b1;
        ST_HOLD: begin
          if (req_eff[owner]) begin
            gnt_vld = 1'b1;
            gnt_idx = owner;
            hold_n  = hold_cnt + 1'b1;
            if (hold_cnt + 1'b1 == HOLD_W'(MAX_HOLD)) begin
              ptr_n   = wrap_inc(owner);
              state_n = ST_ARB;
            end
          end else begin
            // Owner dropped: release and arbitrate from owner+1 in this same cycle.
            arb_ptr = wrap_inc(owner);
            ptr_n   = arb_ptr;
            state_n = ST_ARB;
            do_arb  = 1'b1;
          end
        end
        default: ;
      endcase

      if (do_arb) begin
        pick = rr_first(RR_MAX_N'(req_eff), RR_IDX_W'(arb_ptr), N);
        if (pick.found) begin
          gnt_vld = 1'b1;
          // Narrow the package-width index back to SRC_W.
          for (int unsigned k = 0; k < N; k++)
            if (pick.idx == RR_IDX_W'(k)) gnt_idx = SRC_W'(k);
          owner_n = gnt_idx;
          hold_n  = HOLD_W'(1);
          if (MAX_HOLD == 1) begin
            ptr_n   = wrap_inc(gnt_idx);
            state_n = ST_ARB;
          end else begin
            state_n = ST_HOLD;
          end
        end
      end
    end
  end

  always_comb begin
    o_Grant = '0;
    for (int unsigned k = 0; k < N; k++)
      if (gnt_vld && gnt_idx == SRC_W'(k)) o_Grant[k] = 1'b1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_ARB;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      cap_vld  <= 1'b0;
      cap_sel  <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      hold_cnt <= hold_n;
      cap_vld  <= gnt_vld;
      cap_sel  <= gnt_idx;
    end
  end

  assign cap_data  = i_Data[cap_sel*WIDTH +: WIDTH];
  assign buf_wdata = {cap_sel, cap_data};

  arb_out_buf2 #(
    .DW(SRC_W + WIDTH)
  ) u_out_buf (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_Wr    (cap_vld),
    .i_WrData(buf_wdata),
    .o_Valid (o_Valid),
    .o_Data  (buf_rdata),
    .i_Ready (i_Ready),
    .o_Occ   (occ)
  );

  assign o_Src  = buf_rdata[SRC_W+WIDTH-1 -: SRC_W];
  assign o_Data = buf_rdata[WIDTH-1:0];

endmodule
